// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
//
// Sits between the CPU load/store stage and a block-granular data memory.
// Hits complete with zero added latency. A miss stalls the CPU, writes back
// the victim line if it is dirty, refills the line, and then replays the access.
//
// Ports:
//   clock, reset          sole clock; asynchronous active-low reset
//   cpu_ren / cpu_wen     word read / write request (both high = no request)
//   cpu_addr              word address {tag, index, offset}
//   cpu_din / cpu_dout    write data / read data (dout valid on unstalled read)
//   cpu_stall             request not yet complete; CPU holds its inputs stable
//   mem_ren / mem_wen     block read / write request to memory
//   mem_block_address     block address for the current memory request
//   mem_din / mem_dout    victim block to memory / refill block from memory
//   mem_ready / mem_done  refill data valid / write-back complete
module dcache_ctrl #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned BLOCK_SIZE = 8,
  parameter int unsigned MEM_SIZE   = 32,
  parameter int unsigned CACHE_SIZE = 4
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            cpu_ren,
  input  logic                                            cpu_wen,
  input  logic [$clog2(MEM_SIZE)+$clog2(BLOCK_SIZE)-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]                            cpu_din,
  output logic [WORD_SIZE-1:0]                            cpu_dout,
  output logic                                            cpu_stall,
  output logic                                            mem_ren,
  output logic                                            mem_wen,
  output logic [$clog2(MEM_SIZE)-1:0]                     mem_block_address,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0]                 mem_din,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]                 mem_dout,
  input  logic                                            mem_ready,
  input  logic                                            mem_done
);

  localparam int unsigned OffsetW = $clog2(BLOCK_SIZE);
  localparam int unsigned IndexW  = $clog2(CACHE_SIZE);
  localparam int unsigned BlkW    = $clog2(MEM_SIZE);
  localparam int unsigned TagW    = BlkW - IndexW;
  localparam int unsigned LineW   = WORD_SIZE * BLOCK_SIZE;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWriteback = 3'd1;
  localparam logic [2:0] StGapWb     = 3'd2;
  localparam logic [2:0] StAllocate  = 3'd3;
  localparam logic [2:0] StGapRf     = 3'd4;

  logic [2:0] state_q, state_d;

  // Per-line state. Only valid/dirty are reset; tags and data come up unknown
  // and are never looked at until the line has been refilled.
  logic [CACHE_SIZE-1:0] valid_q;
  logic [CACHE_SIZE-1:0] dirty_q;
  logic [TagW-1:0]       tag_q  [CACHE_SIZE];
  logic [LineW-1:0]      data_q [CACHE_SIZE];

  logic [OffsetW-1:0] offset;
  logic [IndexW-1:0]  index;
  logic [TagW-1:0]    tag_in;

  assign offset = cpu_addr[OffsetW-1:0];
  assign index  = cpu_addr[OffsetW +: IndexW];
  assign tag_in = cpu_addr[OffsetW+IndexW +: TagW];

  logic             request, read_req, write_req, idle, hit;
  logic             rd_hit, wr_hit, refill;
  logic [LineW-1:0] line_data, wr_block;
  logic [WORD_SIZE-1:0] line_words [BLOCK_SIZE];

  // Both enables high is treated as no request at all.
  assign read_req  = cpu_ren & ~cpu_wen;
  assign write_req = cpu_wen & ~cpu_ren;
  assign request   = read_req | write_req;

  assign idle      = (state_q == StIdle);
  assign line_data = data_q[index];
  assign hit       = valid_q[index] && (tag_q[index] == tag_in);

  assign rd_hit    = read_req & idle & hit;
  assign wr_hit    = write_req & idle & hit;
  assign refill    = (state_q == StAllocate) & mem_ready;

  always_comb begin
    for (int w = 0; w < BLOCK_SIZE; w++) begin
      line_words[w] = line_data[w*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Line image with the addressed word replaced by the store data.
  always_comb begin
    wr_block = line_data;
    for (int w = 0; w < BLOCK_SIZE; w++) begin
      if (OffsetW'(w) == offset) begin
        wr_block[w*WORD_SIZE +: WORD_SIZE] = cpu_din;
      end
    end
  end

  assign cpu_stall = request & (~idle | ~hit);
  assign cpu_dout  = rd_hit ? line_words[offset] : '0;

  // Memory strobes depend on registered state only, so they are glitch-free
  // with respect to the CPU inputs and can never be high together.
  assign mem_wen = (state_q == StWriteback);
  assign mem_ren = (state_q == StAllocate);
  assign mem_din = mem_wen ? line_data : '0;

  always_comb begin
    mem_block_address = '0;
    if (mem_wen) begin
      mem_block_address = {tag_q[index], index};
    end else if (mem_ren) begin
      mem_block_address = {tag_in, index};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (request && !hit) begin
          state_d = (valid_q[index] && dirty_q[index]) ? StWriteback : StAllocate;
        end
      end
      StWriteback: if (mem_done)  state_d = StGapWb;
      // One quiet cycle lets the memory re-arm its access delay.
      StGapWb:                    state_d = StAllocate;
      StAllocate:  if (mem_ready) state_d = StGapRf;
      // mem_ready may still be high here; it is not looked at.
      StGapRf:                    state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (refill) begin
      data_q[index] <= mem_dout;
      tag_q[index]  <= tag_in;
    end else if (wr_hit) begin
      data_q[index] <= wr_block;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && cpu_ren && cpu_wen) begin
      $display("%m: error: cpu_ren and cpu_wen both high at %0t, request ignored", $time);
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the CPU load/store stage and the block-granular data memory (Dmem).
- Serves word reads and writes from the CPU. On a miss it stalls the CPU, writes back a dirty victim block, refills the line from memory, then replays the access.

Parameters:
- WORD_SIZE, 32, bits per word.
- BLOCK_SIZE, 8, words per block/line (power of 2).
- MEM_SIZE, 32, blocks in backing memory (power of 2).
- CACHE_SIZE, 4, lines in cache (power of 2, ≤ MEM_SIZE).

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, asynchronous, active-low reset.
- cpu_ren, input, 1, word read request.
- cpu_wen, input, 1, word write request.
- cpu_addr, input, clog2(MEM_SIZE)+clog2(BLOCK_SIZE), word address = {tag, index, offset}.
- cpu_din, input, WORD_SIZE, write data.
- cpu_dout, output, WORD_SIZE, read data; valid when cpu_ren=1 and cpu_stall=0.
- cpu_stall, output, 1, request not yet complete; CPU holds all request inputs stable while it is high.
- mem_ren, output, 1, block read request to memory.
- mem_wen, output, 1, block write request to memory.
- mem_block_address, output, clog2(MEM_SIZE), block address.
- mem_din, output, WORD_SIZE*BLOCK_SIZE, victim block to memory.
- mem_dout, input, WORD_SIZE*BLOCK_SIZE, refill block from memory.
- mem_ready, input, 1, read data valid.
- mem_done, input, 1, write complete.

Behaviour:
- Per line state: valid bit, dirty bit, tag, data block. Reset clears every valid and dirty bit; data and tag arrays are not reset.
- Address split: offset = low clog2(BLOCK_SIZE) bits, index = next clog2(CACHE_SIZE) bits, tag = remaining bits.
- hit = valid[index] && tag match. Refill and victim addresses:
  - refill address = cpu_addr[upper bits] = {tag, index}.
  - victim address = {stored tag, index}.
- Reset values (async, immediate): state IDLE, mem_ren=0, mem_wen=0, mem_block_address=0, mem_din=0, cpu_stall=0 while no request, cpu_dout=0.
- cpu_ren && cpu_wen both high: treated as no request (stall 0, no state change), plus a simulation $display error. Neither high: idle, stall 0.
- FSM states:
  - IDLE
    - Hit read: cpu_dout = line word (combinational), stall 0, zero added latency.
    - Hit write: word updated at next edge, dirty set, stall 0.
    - Miss with valid && dirty: stall 1, go to WRITEBACK. Otherwise stall 1, go to ALLOCATE.
  - WRITEBACK: mem_wen=1, mem_block_address = victim address, mem_din = line data, all held until mem_done=1; then go to GAP_WB.
  - GAP_WB: one cycle with mem_ren=mem_wen=0, which re-arms the memory delay counter; go to ALLOCATE.
  - ALLOCATE: mem_ren=1, mem_block_address = refill address, held until mem_ready=1. On that edge the controller:
    - captures mem_dout into the line;
    - writes the tag and sets valid;
    - clears dirty;
    - goes to GAP_RF.
  - GAP_RF: one cycle with mem_ren=mem_wen=0 (the stale registered mem_ready is ignored here); go to IDLE.
  - IDLE after GAP_RF: the replayed access now hits, completing as a normal hit; a write replay sets dirty. Stall stays 1 through WRITEBACK, GAP_WB, ALLOCATE and GAP_RF.
- mem_ren and mem_wen are never high together and are decoded from registered state only.
- mem_ready and mem_done are ignored outside ALLOCATE and WRITEBACK respectively.
- cpu_stall = request && (state != IDLE || !hit). cpu_dout = 0 unless a read hit in IDLE.
- Miss penalty with default memory delay D: clean miss = D+2 stall cycles; dirty miss = 2D+3 stall cycles (exact D taken from memory handshake).
- Reset asserted mid-transaction: FSM returns to IDLE at once, memory requests drop, all lines invalid. The partially refilled line stays invalid.
- Request dropped by the CPU mid-miss is illegal; the in-flight memory transaction still completes.

Test Plan:
- Cold read at addr 0x00, memory block 0 word 0 = 0x00000011 → stall until refill, mem_ren pulses once with block 0, then cpu_dout=0x00000011, stall 0.
- Read 0x05 right after → hit, stall 0 same cycle, cpu_dout = block 0 word 5, no mem_ren.
- Write 0xDEADBEEF to 0x02 (hit) then read 0x20 (same index 0, tag 1) → WRITEBACK to block 0 with word 2 = 0xDEADBEEF, one cycle with mem_ren=mem_wen=0, refill block 4, read completes.
- Read 0x08 (index 1, clean) then 0x28 (conflict) → no mem_wen, refill only, stall = D+2 cycles.
- Reset low during ALLOCATE → mem_ren=0 immediately; read 0x00 after release misses again.
- cpu_ren=cpu_wen=1 → stall 0, no memory traffic, error message printed, line contents unchanged.
